// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the pipelined RISC-V core.
//   arb_state_t     state encoding of the IF/MEM memory arbiter
//   OPC_*           major opcodes (load/store/branch/ALU) shared with control
//   isMemOpcode()   true for opcodes that need the load/store port
package core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE_I,
        DONE_D
    } arb_state_t;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_ALU     = 7'b0110011;
    localparam logic [6:0] OPC_ALU_IMM = 7'b0010011;

    function automatic logic isMemOpcode(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: all bus signals around the IF/MEM memory arbiter.
//   IF port   : if_req, if_addr -> if_rdata, if_valid, if_stall
//   Data port : d_rd, d_wr, d_addr, d_wdata, d_be -> d_rdata, d_valid, d_stall
//   Memory    : mem_req, mem_we, mem_addr, mem_wdata, mem_be <- mem_rdata, mem_ack
//   Status    : busy
// Modports:
//   slave  - the arbiter itself (serves both core ports, drives the memory)
//   master - the surrounding core pipeline and memory model
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_valid, if_stall,
        input  d_rd, d_wr, d_addr, d_wdata, d_be,
        output d_rdata, d_valid, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_valid, if_stall,
        output d_rd, d_wr, d_addr, d_wdata, d_be,
        input  d_rdata, d_valid, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack,
        input  busy
    );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and
// load/store. One transaction at a time; the data port wins ties so the older
// instruction drains first.
// Ports:
//   clk    - clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - mem_arbiter_if.slave (IF port, data port, memory port, busy)
// The memory-side outputs are registered at grant and held until mem_ack.
// Each completed access produces a one-cycle valid pulse on its port; stalls
// are the only combinational outputs.
module mem_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t        stateReg, stateNext;

    logic              memReqReg, memReqNext;
    logic              memWeReg, memWeNext;
    logic [ADDR_W-1:0] memAddrReg, memAddrNext;
    logic [DATA_W-1:0] memWdataReg, memWdataNext;
    logic [BE_W-1:0]   memBeReg, memBeNext;
    logic [DATA_W-1:0] ifRdataReg, ifRdataNext;
    logic [DATA_W-1:0] dRdataReg, dRdataNext;
    logic              ifValidReg, ifValidNext;
    logic              dValidReg, dValidNext;

    logic              dReq;
    logic              grantD;
    logic              grantI;

    assign dReq = bus.d_rd | bus.d_wr;

    always_comb begin
        stateNext    = stateReg;
        memReqNext   = memReqReg;
        memWeNext    = memWeReg;
        memAddrNext  = memAddrReg;
        memWdataNext = memWdataReg;
        memBeNext    = memBeReg;
        ifRdataNext  = ifRdataReg;
        dRdataNext   = dRdataReg;
        ifValidNext  = 1'b0;
        dValidNext   = 1'b0;
        grantD       = 1'b0;
        grantI       = 1'b0;

        case (stateReg)
            IDLE: begin
                if (dReq) begin
                    grantD = 1'b1;
                end else if (bus.if_req) begin
                    grantI = 1'b1;
                end
            end
            BUSY_I: begin
                if (bus.mem_ack) begin
                    stateNext   = DONE_I;
                    memReqNext  = 1'b0;
                    memWeNext   = 1'b0;
                    ifRdataNext = bus.mem_rdata;
                    ifValidNext = 1'b1;
                end
            end
            BUSY_D: begin
                if (bus.mem_ack) begin
                    stateNext  = DONE_D;
                    memReqNext = 1'b0;
                    memWeNext  = 1'b0;
                    // A store (including rd+wr together) leaves load data untouched.
                    if (!memWeReg) begin
                        dRdataNext = bus.mem_rdata;
                    end
                    dValidNext = 1'b1;
                end
            end
            // In a completion cycle the served port is still holding its
            // (already finished) request, so only the other port is looked at.
            DONE_I: begin
                if (dReq) begin
                    grantD = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            DONE_D: begin
                if (bus.if_req) begin
                    grantI = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (grantD) begin
            stateNext    = BUSY_D;
            memReqNext   = 1'b1;
            memWeNext    = bus.d_wr;
            memAddrNext  = bus.d_addr;
            memWdataNext = bus.d_wdata;
            memBeNext    = bus.d_wr ? bus.d_be : '1;
        end else if (grantI) begin
            stateNext    = BUSY_I;
            memReqNext   = 1'b1;
            memWeNext    = 1'b0;
            memAddrNext  = bus.if_addr;
            memWdataNext = '0;
            memBeNext    = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= IDLE;
            memReqReg   <= 1'b0;
            memWeReg    <= 1'b0;
            memAddrReg  <= '0;
            memWdataReg <= '0;
            memBeReg    <= '0;
            ifRdataReg  <= '0;
            dRdataReg   <= '0;
            ifValidReg  <= 1'b0;
            dValidReg   <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            memReqReg   <= memReqNext;
            memWeReg    <= memWeNext;
            memAddrReg  <= memAddrNext;
            memWdataReg <= memWdataNext;
            memBeReg    <= memBeNext;
            ifRdataReg  <= ifRdataNext;
            dRdataReg   <= dRdataNext;
            ifValidReg  <= ifValidNext;
            dValidReg   <= dValidNext;
        end
    end

    assign bus.mem_req   = memReqReg;
    assign bus.mem_we    = memWeReg;
    assign bus.mem_addr  = memAddrReg;
    assign bus.mem_wdata = memWdataReg;
    assign bus.mem_be    = memBeReg;
    assign bus.if_rdata  = ifRdataReg;
    assign bus.d_rdata   = dRdataReg;
    assign bus.if_valid  = ifValidReg;
    assign bus.d_valid   = dValidReg;
    assign bus.busy      = (stateReg != IDLE);

    assign bus.if_stall  = bus.if_req & ~ifValidReg;
    assign bus.d_stall   = dReq & ~dValidReg;

endmodule
